hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Backward-direction companion to the decode-to-execute pipeline register.
- Consumes that register's control and destination outputs (execute stage) plus the decode-stage source operands.
- Returns stall, flush and operand-forwarding controls upstream.
- Keeps shadow copies of the memory and writeback stages, runs a load-use stall FSM and counts stall cycles.

Parameters:
REGISTER_SIZE, 6, width of register specifiers
LOAD_STALL, 1, bubbles inserted on a load-use hazard (legal 1..3)
CNT_WIDTH, 16, width of saturating stall-cycle counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
RsD  input  REGISTER_SIZE  decode-stage source A specifier
RtD  input  REGISTER_SIZE  decode-stage source B specifier
UsesRsD  input  1  decode instruction reads RsD
UsesRtD  input  1  decode instruction reads RtD
ValidD  input  1  decode slot holds a real instruction
RsE  input  REGISTER_SIZE  execute-stage source A specifier
RtE  input  REGISTER_SIZE  execute-stage source B specifier
ValidE  input  1  execute slot holds a real instruction
RegWriteE  input  1  execute instruction writes a register
MemtoRegE  input  1  execute instruction is a load
WriteRegE  input  REGISTER_SIZE  execute destination (post RegDst mux)
FlushReq  input  1  redirect (taken branch/jump), kills decode and execute
StallF  output  1  hold PC (drive PCEnD low)
StallD  output  1  hold fetch/decode register
FlushE  output  1  load bubble into decode/execute register next edge
ForwardAE  output  2  source A select: 00 register file, 10 memory-stage result, 01 writeback result
ForwardBE  output  2  source B select, same encoding
StallCount  output  CNT_WIDTH  total stall cycles since reset, saturating

Behaviour:
- Reset (RST_N low at edge):
  - FSM goes to IDLE; counter and StallCount clear to 0.
  - Shadow M and W entries are cleared to invalid.
  - Outputs during reset: StallF=StallD=FlushE=0, ForwardAE=ForwardBE=00.
  - A reset arriving mid-stall aborts the stall.
- Shadow pipeline:
  - Each edge: M <= {ValidE, RegWriteE, MemtoRegE, WriteRegE}; W <= M.
  - Advances unconditionally; stalls never freeze M/W.
- Register 0 never matches; any specifier equal to 0 yields no hazard and no forward.
- Match rule: a stage matches a source when the entry is valid, has RegWrite=1, and its destination equals the source.
- Forwarding (combinational, for the execute instruction):
  - Source A: if ValidE and M matches RsE and M is not a load -> 10.
  - Else if W matches RsE -> 01.
  - Else 00.
  - Source B: same rule using RtE.
  - M has priority over W.
- Load-use detect (combinational):
  - Fires when ValidD and (UsesRsD and RsD==WriteRegE, or UsesRtD and RtD==WriteRegE).
  - Also requires ValidE, RegWriteE=1, MemtoRegE=1 and WriteRegE!=0.
- FSM states IDLE, STALL:
  - IDLE: on detect and not FlushReq, assert StallF=StallD=FlushE=1 this cycle. Load the counter with LOAD_STALL-1. Go to STALL if LOAD_STALL>1, else stay in IDLE.
  - STALL: assert StallF=StallD=FlushE=1. Decrement the counter; when the counter is 0, return to IDLE at this edge.
  - The execute slot holds a bubble during STALL, so detect is not re-evaluated there.
- Loaded data beyond W comes from the register file. Register-file write-before-read is a decided property of the register file.
- FlushReq:
  - FlushE=1, StallF=StallD=0, FSM forced to IDLE with counter cleared at that edge.
  - Flush overrides a simultaneous detect or an active STALL.
- StallCount: increments on every cycle with StallF=1; holds at all-ones.
- Latency: all outputs except StallCount are combinational from inputs and state, with no added cycle. StallCount reflects stalls up to the previous edge.

Test Plan:
- Back-to-back ALU ops: E writes r5 (non-load), next cycle E reads RsE=r5 with M holding r5 -> ForwardAE=10, no stall, StallCount stays 0.
- Two-apart dependency: r7 written, one unrelated instruction, then RtE=r7 with W holding r7 -> ForwardBE=01. Same case with M also writing r7 -> ForwardBE=10 (priority).
- Load-use, LOAD_STALL=1: E is a load to r3 and D reads RsD=r3 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle ForwardAE=01, StallCount=1.
- Load-use with LOAD_STALL=3 -> 3 consecutive stall cycles, then release. StallCount=3. After release, source read from the register file (ForwardAE=00).
- Load-use with FlushReq asserted in the same cycle -> FlushE=1, StallF=0, no stall, StallCount=0. Separately, FlushReq during the 2nd STALL cycle -> immediate IDLE.
- Register 0 and reset: load to r0 with D reading r0 -> no stall, no forward. RST_N low during STALL -> next cycle all outputs 0 and StallCount=0. Forcing the counter near saturation holds it at all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard control for the decode-to-execute pipeline register. Tracks shadow
// copies of the memory and writeback stages, selects operand forwarding for
// the execute instruction, runs the load-use stall FSM and counts stall cycles.
module hazard_ctrl #(
  parameter int REGISTER_SIZE = 6,
  parameter int LOAD_STALL    = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [REGISTER_SIZE-1:0] RsD,
  input  logic [REGISTER_SIZE-1:0] RtD,
  input  logic                     UsesRsD,
  input  logic                     UsesRtD,
  input  logic                     ValidD,
  input  logic [REGISTER_SIZE-1:0] RsE,
  input  logic [REGISTER_SIZE-1:0] RtE,
  input  logic                     ValidE,
  input  logic                     RegWriteE,
  input  logic                     MemtoRegE,
  input  logic [REGISTER_SIZE-1:0] WriteRegE,
  input  logic                     FlushReq,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     FlushE,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic [CNT_WIDTH-1:0]     StallCount
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] LS_M1   = 2'(LOAD_STALL - 1);
  localparam logic       MULTI   = (LOAD_STALL > 1);
  localparam logic [REGISTER_SIZE-1:0] REG_ZERO = {REGISTER_SIZE{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]     stall_cnt_q;

  // Shadow memory-stage entry
  logic                     m_valid_q, m_wr_q, m_load_q;
  logic [REGISTER_SIZE-1:0] m_dst_q;
  // Shadow writeback-stage entry (load flag not needed past memory)
  logic                     w_valid_q, w_wr_q;
  logic [REGISTER_SIZE-1:0] w_dst_q;

  logic                     load_use_s;
  logic                     stall_s, flush_s;
  logic [1:0]               fwd_a_s, fwd_b_s;

  // Forward select for one execute source: memory result beats writeback.
  function automatic logic [1:0] fwd_sel(input logic [REGISTER_SIZE-1:0] src,
                                         input logic valid_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != REG_ZERO) begin
      if (valid_e && m_valid_q && m_wr_q && !m_load_q && (m_dst_q == src)) begin
        sel = 2'b10;
      end else if (w_valid_q && w_wr_q && (w_dst_q == src)) begin
        sel = 2'b01;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Shadow pipeline advances every edge, independent of stalls.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      m_valid_q <= 1'b0;
      m_wr_q    <= 1'b0;
      m_load_q  <= 1'b0;
      m_dst_q   <= REG_ZERO;
      w_valid_q <= 1'b0;
      w_wr_q    <= 1'b0;
      w_dst_q   <= REG_ZERO;
    end else begin
      m_valid_q <= ValidE;
      m_wr_q    <= RegWriteE;
      m_load_q  <= MemtoRegE;
      m_dst_q   <= WriteRegE;
      w_valid_q <= m_valid_q;
      w_wr_q    <= m_wr_q;
      w_dst_q   <= m_dst_q;
    end
  end

  // Load-use detect: decode reads the destination of a load sitting in execute.
  always_comb begin
    load_use_s = 1'b0;
    if (ValidD && ValidE && RegWriteE && MemtoRegE && (WriteRegE != REG_ZERO)) begin
      load_use_s = (UsesRsD && (RsD == WriteRegE)) || (UsesRtD && (RtD == WriteRegE));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Stall FSM next state; a redirect always wins and clears any pending stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (FlushReq) begin
      flush_s = 1'b1;
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use_s) begin
            stall_s = 1'b1;
            flush_s = 1'b1;
            cnt_d   = LS_M1;
            state_d = MULTI ? STALL : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        STALL: begin
          stall_s = 1'b1;
          flush_s = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          state_d = (cnt_q == 2'd1) ? IDLE : STALL;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output drive: everything held quiet while reset is asserted.
  always_comb begin
    fwd_a_s = fwd_sel(RsE, ValidE);
    fwd_b_s = fwd_sel(RtE, ValidE);
    if (RST_N) begin
      StallF    = stall_s;
      StallD    = stall_s;
      FlushE    = flush_s;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end else begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Saturating count of cycles with the fetch stage held.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else if (StallF && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-bubble/16-bit counter and
// 3-bubble/4-bit counter) share one stimulus stream and are compared every
// cycle against a behavioural model, plus directed literal expectations.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] RsD, RtD, RsE, RtE, WriteRegE;
  logic       UsesRsD, UsesRtD, ValidD, ValidE, RegWriteE, MemtoRegE, FlushReq;

  logic       sf0, sd0, fe0, sf1, sd1, fe1;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int total = 0;
  int bad   = 0;

  // Model state: shadow history (0 = memory stage, 1 = writeback stage)
  logic       hv[2], hw[2], hl[2];
  logic [5:0] hd[2];
  int         rem[2];
  int         cnt[2];
  int         ls[2]   = '{1, 3};
  int         cmax[2] = '{65535, 15};

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REGISTER_SIZE(6), .LOAD_STALL(1), .CNT_WIDTH(16)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD),
    .UsesRtD(UsesRtD), .ValidD(ValidD), .RsE(RsE), .RtE(RtE), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .FlushReq(FlushReq), .StallF(sf0), .StallD(sd0), .FlushE(fe0),
    .ForwardAE(fa0), .ForwardBE(fb0), .StallCount(sc0));

  hazard_ctrl #(.REGISTER_SIZE(6), .LOAD_STALL(3), .CNT_WIDTH(4)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD),
    .UsesRtD(UsesRtD), .ValidD(ValidD), .RsE(RsE), .RtE(RtE), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .FlushReq(FlushReq), .StallF(sf1), .StallD(sd1), .FlushE(fe1),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallCount(sc1));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic detect();
    if (!(ValidD && ValidE && RegWriteE && MemtoRegE) || WriteRegE == 6'd0) return 1'b0;
    return (UsesRsD && RsD == WriteRegE) || (UsesRtD && RtD == WriteRegE);
  endfunction

  function automatic int exp_stall(input int i);
    if (!RST_N || FlushReq) return 0;
    return (rem[i] > 0 || detect()) ? 1 : 0;
  endfunction

  function automatic int exp_fwd(input logic [5:0] src);
    if (!RST_N || src == 6'd0) return 0;
    if (ValidE && hv[0] && hw[0] && !hl[0] && hd[0] == src) return 2;
    if (hv[1] && hw[1] && hd[1] == src) return 1;
    return 0;
  endfunction

  // Compare both instances against the model at the falling edge.
  task automatic cyc_check();
    int s0, s1, fx;
    @(negedge CLK);
    s0 = exp_stall(0);
    s1 = exp_stall(1);
    fx = (RST_N && FlushReq) ? 1 : 0;
    chk("d0_stallf", int'(sf0), s0);
    chk("d0_stalld", int'(sd0), s0);
    chk("d0_flushe", int'(fe0), (s0 == 1 || fx == 1) ? 1 : 0);
    chk("d0_fwda",   int'(fa0), exp_fwd(RsE));
    chk("d0_fwdb",   int'(fb0), exp_fwd(RtE));
    chk("d0_count",  int'(sc0), cnt[0]);
    chk("d1_stallf", int'(sf1), s1);
    chk("d1_stalld", int'(sd1), s1);
    chk("d1_flushe", int'(fe1), (s1 == 1 || fx == 1) ? 1 : 0);
    chk("d1_fwda",   int'(fa1), exp_fwd(RsE));
    chk("d1_fwdb",   int'(fb1), exp_fwd(RtE));
    chk("d1_count",  int'(sc1), cnt[1]);
  endtask

  // Advance the model across the rising edge, then let inputs change.
  task automatic adv();
    int st[2];
    @(posedge CLK);
    for (int i = 0; i < 2; i++) st[i] = exp_stall(i);
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        hv[i] = 1'b0; hw[i] = 1'b0; hl[i] = 1'b0; hd[i] = 6'd0;
        rem[i] = 0; cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (st[i] == 1 && cnt[i] < cmax[i]) cnt[i]++;
        if (FlushReq) rem[i] = 0;
        else if (rem[i] > 0) rem[i]--;
        else if (detect()) rem[i] = ls[i] - 1;
      end
      hv[1] = hv[0]; hw[1] = hw[0]; hl[1] = hl[0]; hd[1] = hd[0];
      hv[0] = ValidE; hw[0] = RegWriteE; hl[0] = MemtoRegE; hd[0] = WriteRegE;
    end
    #1;
  endtask

  task automatic idle();
    RST_N = 1'b1; FlushReq = 1'b0;
    RsD = 6'd0; RtD = 6'd0; UsesRsD = 1'b0; UsesRtD = 1'b0; ValidD = 1'b0;
    RsE = 6'd0; RtE = 6'd0; ValidE = 1'b0; RegWriteE = 1'b0; MemtoRegE = 1'b0;
    WriteRegE = 6'd0;
  endtask

  task automatic e_write(input logic [5:0] dst, input logic load);
    ValidE = 1'b1; RegWriteE = 1'b1; MemtoRegE = load; WriteRegE = dst;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hv[i] = 1'b0; hw[i] = 1'b0; hl[i] = 1'b0; hd[i] = 6'd0;
      rem[i] = 0; cnt[i] = 0;
    end
    idle();
    // Reset with busy inputs: outputs must be quiet
    RST_N = 1'b0; e_write(6'd3, 1'b1); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin hv[i] = 1'b0; hw[i] = 1'b0; cnt[i] = 0; rem[i] = 0; end
    cyc_check();
    chk("rst_stallf", int'(sf0), 0); chk("rst_flushe", int'(fe1), 0);
    adv();
    idle(); cyc_check();
    chk("rst_count0", int'(sc0), 0); chk("rst_count1", int'(sc1), 0);
    adv();

    // Back-to-back ALU forward from memory stage
    idle(); e_write(6'd5, 1'b0); cyc_check(); adv();
    idle(); ValidE = 1'b1; RsE = 6'd5; cyc_check();
    chk("alu_fwda", int'(fa0), 2); chk("alu_nostall", int'(sf0), 0);
    adv();
    idle(); cyc_check(); chk("alu_count", int'(sc0), 0); adv();

    // Two-apart: writeback forward, then memory priority
    idle(); e_write(6'd7, 1'b0); cyc_check(); adv();
    idle(); e_write(6'd9, 1'b0); cyc_check(); adv();
    idle(); ValidE = 1'b1; RtE = 6'd7; cyc_check();
    chk("wb_fwdb", int'(fb0), 1); adv();
    idle(); e_write(6'd7, 1'b0); cyc_check(); adv();
    idle(); e_write(6'd7, 1'b0); cyc_check(); adv();
    idle(); ValidE = 1'b1; RtE = 6'd7; cyc_check();
    chk("prio_fwdb", int'(fb1), 2); adv();

    // Load-use: 1 bubble on dut0, 3 on dut1
    idle(); e_write(6'd3, 1'b1); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3; cyc_check();
    chk("lu_stall0", int'(sf0), 1); chk("lu_stall1", int'(sd1), 1); adv();
    idle(); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3; cyc_check();
    chk("lu1_release", int'(sf0), 0); chk("lu3_hold", int'(sf1), 1); adv();
    idle(); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3; ValidE = 1'b1; RsE = 6'd3; cyc_check();
    chk("lu_fwda_wb", int'(fa0), 1); chk("lu3_hold2", int'(sf1), 1); adv();
    idle(); ValidE = 1'b1; RsE = 6'd3; cyc_check();
    chk("lu3_release", int'(sf1), 0); chk("lu_fwda_rf", int'(fa1), 0);
    chk("lu_count0", int'(sc0), 1); chk("lu_count1", int'(sc1), 3); adv();

    // Flush with simultaneous detect, then flush in 2nd stall cycle
    idle(); e_write(6'd4, 1'b1); ValidD = 1'b1; UsesRtD = 1'b1; RtD = 6'd4; FlushReq = 1'b1;
    cyc_check(); chk("fl_stall", int'(sf1), 0); chk("fl_flushe", int'(fe0), 1); adv();
    idle(); cyc_check(); chk("fl_count0", int'(sc0), 1); chk("fl_count1", int'(sc1), 3); adv();
    idle(); e_write(6'd4, 1'b1); ValidD = 1'b1; UsesRtD = 1'b1; RtD = 6'd4; cyc_check(); adv();
    idle(); ValidD = 1'b1; UsesRtD = 1'b1; RtD = 6'd4; FlushReq = 1'b1; cyc_check();
    chk("fl2_stall", int'(sf1), 0); chk("fl2_flushe", int'(fe1), 1); adv();
    idle(); cyc_check(); chk("fl2_idle", int'(sf1), 0);
    chk("fl2_count0", int'(sc0), 2); chk("fl2_count1", int'(sc1), 4); adv();

    // Register 0 never hazards or forwards
    idle(); e_write(6'd0, 1'b1); ValidD = 1'b1; UsesRsD = 1'b1; cyc_check();
    chk("r0_stall", int'(sf0), 0); adv();
    idle(); e_write(6'd0, 1'b0); cyc_check(); adv();
    idle(); ValidE = 1'b1; cyc_check(); chk("r0_fwda", int'(fa0), 0); adv();

    // Reset during stall aborts it
    idle(); e_write(6'd3, 1'b1); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3; cyc_check(); adv();
    RST_N = 1'b0; cyc_check();
    chk("rs_stallf", int'(sf1), 0); chk("rs_flushe", int'(fe1), 0); adv();
    idle(); cyc_check();
    chk("rs_stall1", int'(sf1), 0); chk("rs_count0", int'(sc0), 0); chk("rs_count1", int'(sc1), 0); adv();

    // Saturation of the narrow counter
    for (int k = 0; k < 20; k++) begin
      idle(); e_write(6'd3, 1'b1); ValidD = 1'b1; UsesRsD = 1'b1; RsD = 6'd3; cyc_check(); adv();
    end
    idle(); cyc_check(); chk("sat_count1", int'(sc1), 15); chk("sat_count0", int'(sc0), 20); adv();

    // Randomized phase, small register numbers to provoke hazards
    for (int k = 0; k < 2000; k++) begin
      RST_N     = ($urandom_range(0, 63) != 0);
      FlushReq  = ($urandom_range(0, 15) == 0);
      RsD       = 6'($urandom_range(0, 3));
      RtD       = 6'($urandom_range(0, 3));
      UsesRsD   = 1'($urandom);
      UsesRtD   = 1'($urandom);
      ValidD    = 1'($urandom);
      RsE       = 6'($urandom_range(0, 3));
      RtE       = 6'($urandom_range(0, 3));
      ValidE    = ($urandom_range(0, 3) != 0);
      RegWriteE = 1'($urandom);
      MemtoRegE = 1'($urandom);
      WriteRegE = 6'($urandom_range(0, 3));
      cyc_check();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
